// File: rtl/diag_loop_seq_pkg.sv
// Shared types and constants for the diagnostic loop-chain sequencer.
package diag_loop_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_SCAN,
    S_SETTLE,
    S_DONE
  } state_t;

  // Fault memory returns data this many cycles after the read strobe.
  localparam int FMEM_RD_LAT = 1;

endpackage

// File: rtl/diag_loop_seq_if.sv
// Fault-memory read port, chain control/observation and report stream.
interface diag_loop_if #(
  parameter int SYSTOLIC_SIZE = 8,
  parameter int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE)
) ();
  logic                     fmem_rd;
  logic [ADDR_WIDTH-1:0]    fmem_addr;
  logic [SYSTOLIC_SIZE-1:0] fmem_rdata;

  logic                     chain_rst_n;
  logic                     chain_start_en;
  logic [SYSTOLIC_SIZE-1:0] chain_col_inputs;
  logic [SYSTOLIC_SIZE-1:0] single_pe_detection;
  logic [SYSTOLIC_SIZE-1:0] column_fault_detection;
  logic [SYSTOLIC_SIZE-1:0] row_fault_detection;

  logic                     rpt_valid;
  logic                     rpt_ready;
  logic [ADDR_WIDTH-1:0]    rpt_row;
  logic [SYSTOLIC_SIZE-1:0] rpt_pe_map;

  modport master (
    output fmem_rd, fmem_addr, chain_rst_n, chain_start_en, chain_col_inputs,
           rpt_valid, rpt_row, rpt_pe_map,
    input  fmem_rdata, single_pe_detection, column_fault_detection,
           row_fault_detection, rpt_ready
  );

  modport slave (
    input  fmem_rd, fmem_addr, chain_rst_n, chain_start_en, chain_col_inputs,
           rpt_valid, rpt_row, rpt_pe_map,
    output fmem_rdata, single_pe_detection, column_fault_detection,
           row_fault_detection, rpt_ready
  );
endinterface

// File: rtl/diag_loop_seq_accum.sv
// Sticky OR of the chain's column and row fault verdicts.
module diag_fault_accum #(
  parameter int SYSTOLIC_SIZE = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic [SYSTOLIC_SIZE-1:0] col_in,
  input  logic [SYSTOLIC_SIZE-1:0] row_in,
  output logic [SYSTOLIC_SIZE-1:0] col_sum,
  output logic                     row_flag
);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      col_sum  <= '0;
      row_flag <= 1'b0;
    end else if (en) begin
      col_sum  <= col_sum | col_in;
      row_flag <= row_flag | (|row_in);
    end
  end

endmodule

// File: rtl/diag_loop_seq.sv
// Sequencer: clear chain, load fault rows, rotate loop once for per-row reports.
module diag_loop_seq
  import diag_loop_seq_pkg::*;
#(
  parameter int SYSTOLIC_SIZE = 8,
  parameter int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [SYSTOLIC_SIZE-1:0] col_fault_sum,
  output logic                     row_fault_flag,
  diag_loop_if.master              bus
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(SYSTOLIC_SIZE - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] row_cnt;
  logic [ADDR_WIDTH-1:0] beat_cnt;
  logic                  chain_rst_q;
  logic                  fmem_rd_q;
  logic [ADDR_WIDTH-1:0] fmem_addr_q;
  logic                  scan_hs;
  logic                  acc_en;
  logic                  acc_clr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      row_cnt     <= '0;
      beat_cnt    <= '0;
      chain_rst_q <= 1'b0;
      fmem_rd_q   <= 1'b0;
      fmem_addr_q <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          chain_rst_q <= 1'b1;
          if (start) begin
            state       <= S_CLEAR;
            busy        <= 1'b1;
            chain_rst_q <= 1'b0;
            fmem_rd_q   <= 1'b1;
            fmem_addr_q <= '0;
          end
        end
        S_CLEAR: begin
          state       <= S_LOAD;
          row_cnt     <= '0;
          chain_rst_q <= 1'b1;
          fmem_rd_q   <= 1'b1;
          fmem_addr_q <= ADDR_WIDTH'(1);
        end
        S_LOAD: begin
          // Prefetch row r+2 so it lands while the chain eats row r+1.
          if (int'(row_cnt) + 2 < SYSTOLIC_SIZE) begin
            fmem_rd_q   <= 1'b1;
            fmem_addr_q <= row_cnt + ADDR_WIDTH'(2);
          end else begin
            fmem_rd_q   <= 1'b0;
            fmem_addr_q <= '0;
          end
          if (row_cnt == LAST) begin
            state    <= S_SCAN;
            beat_cnt <= '0;
          end else begin
            row_cnt <= row_cnt + ADDR_WIDTH'(1);
          end
        end
        S_SCAN: begin
          if (bus.rpt_ready) begin
            if (beat_cnt == LAST) state <= S_SETTLE;
            else                  beat_cnt <= beat_cnt + ADDR_WIDTH'(1);
          end
        end
        S_SETTLE: begin
          state <= S_DONE;
          done  <= 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // The chain only advances on an accepted beat, so the head row stays put under stall.
  assign scan_hs              = (state == S_SCAN) && bus.rpt_ready;
  assign bus.rpt_valid        = (state == S_SCAN);
  assign bus.rpt_row          = bus.rpt_valid ? beat_cnt : '0;
  assign bus.rpt_pe_map       = bus.rpt_valid ? bus.single_pe_detection : '0;
  assign bus.chain_start_en   = (state == S_LOAD) || scan_hs;
  assign bus.chain_col_inputs = (state == S_LOAD) ? bus.fmem_rdata : '0;
  assign bus.chain_rst_n      = chain_rst_q;
  assign bus.fmem_rd          = fmem_rd_q;
  assign bus.fmem_addr        = fmem_addr_q;

  // SETTLE picks up the column verdict that lags the final rotation by a cycle.
  assign acc_en  = scan_hs || (state == S_SETTLE);
  assign acc_clr = (state == S_IDLE) && start;

  diag_fault_accum #(.SYSTOLIC_SIZE(SYSTOLIC_SIZE)) u_accum (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (acc_clr),
    .en       (acc_en),
    .col_in   (bus.column_fault_detection),
    .row_in   (bus.row_fault_detection),
    .col_sum  (col_fault_sum),
    .row_flag (row_fault_flag)
  );

endmodule

// File: tb/tb_diag_loop_seq.sv
// Bench for diag_loop_seq with a fault memory and loop-chain environment model.
module tb_diag_loop_seq;

  localparam int N  = 8;
  localparam int AW = $clog2(N);

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         busy;
  logic         done;
  logic [N-1:0] col_fault_sum;
  logic         row_fault_flag;

  int ncmp = 0;
  int nerr = 0;

  logic [N-1:0] mem [N];

  diag_loop_if #(.SYSTOLIC_SIZE(N), .ADDR_WIDTH(AW)) bus ();

  diag_loop_seq #(.SYSTOLIC_SIZE(N), .ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .col_fault_sum  (col_fault_sum),
    .row_fault_flag (row_fault_flag),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  // Fault memory: one-cycle read latency.
  always @(posedge clk)
    if (bus.fmem_rd) bus.fmem_rdata <= mem[bus.fmem_addr];

  // Loop chain: stage 0 takes column inputs OR the head's feedback; head is stage N-1.
  logic [N-1:0] st [N];
  logic [N-1:0] col_reg;
  logic [N-1:0] col_win;

  always_comb begin
    col_win = '0;
    for (int k = 0; k + 2 < N; k++)
      col_win = col_win | (st[k] & st[k+1] & st[k+2]);
  end

  always @(posedge clk) begin
    if (!bus.chain_rst_n) begin
      for (int k = 0; k < N; k++) st[k] <= '0;
      col_reg <= '0;
    end else begin
      if (bus.chain_start_en) begin
        st[0] <= bus.chain_col_inputs | st[N-1];
        for (int k = 1; k < N; k++) st[k] <= st[k-1];
      end
      col_reg <= col_win;
    end
  end

  assign bus.single_pe_detection    = st[N-1];
  assign bus.column_fault_detection = col_reg;

  always_comb begin
    bus.row_fault_detection = '0;
    for (int k = 0; k < N; k++)
      bus.row_fault_detection[k] = ($countones(st[k]) >= 3);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < N; i++) mem[i] = '0;
  endtask

  // One full run; expectations come from the memory image alone:
  // column fault = a column set in three cyclically adjacent rows,
  // row fault = any row with three or more faulty PEs.
  task automatic run_one(input string nm, input int stall_pct, input bit noise);
    logic [N-1:0] exp_col;
    logic         exp_row;
    int cyc, beat, stalls;
    bit fin;
    exp_col = '0;
    exp_row = 1'b0;
    for (int i = 0; i < N; i++) begin
      exp_col = exp_col | (mem[i] & mem[(i+1)%N] & mem[(i+2)%N]);
      if ($countones(mem[i]) >= 3) exp_row = 1'b1;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; beat = 0; stalls = 0; fin = 0;
    while (!fin && cyc < 400) begin
      if (noise) start = ($urandom_range(3) == 0);
      chk({nm, ".busy"}, busy, 1);
      if (bus.rpt_valid) begin
        bus.rpt_ready = ($urandom_range(99) >= stall_pct);
        chk({nm, ".beat_in_range"}, beat < N, 1);
        if (beat < N) begin
          chk({nm, ".rpt_row"}, bus.rpt_row, beat);
          chk({nm, ".rpt_pe_map"}, bus.rpt_pe_map, mem[beat]);
        end
        if (bus.rpt_ready) beat++;
        else               stalls++;
      end else begin
        bus.rpt_ready = $urandom_range(1);
      end
      if (done) begin
        chk({nm, ".latency"}, cyc, 2*N + 3 + stalls);
        chk({nm, ".beats"}, beat, N);
        chk({nm, ".col_fault_sum"}, col_fault_sum, exp_col);
        chk({nm, ".row_fault_flag"}, row_fault_flag, exp_row);
        start = 1'b1;  // must be ignored in the DONE cycle
        fin = 1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (!fin) chk({nm, ".done_timeout"}, 0, 1);
    start = 1'b0;
    chk({nm, ".idle_busy"}, busy, 0);
    chk({nm, ".idle_done"}, done, 0);
    chk({nm, ".sum_hold"}, col_fault_sum, exp_col);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    bus.rpt_ready = 1'b0;
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.chain_rst_n", bus.chain_rst_n, 0);
    chk("rst.rpt_valid", bus.rpt_valid, 0);
    chk("rst.fmem_rd", bus.fmem_rd, 0);
    chk("rst.col_fault_sum", col_fault_sum, 0);
    chk("rst.row_fault_flag", row_fault_flag, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    clear_mem();
    run_one("zero", 0, 0);

    clear_mem(); mem[3] = 8'h10;
    run_one("row3", 0, 0);

    clear_mem(); mem[2] = 8'h01; mem[3] = 8'h01; mem[4] = 8'h01;
    run_one("col0", 0, 0);

    clear_mem(); mem[5] = 8'hE0;
    run_one("row5", 0, 0);

    clear_mem(); mem[1] = 8'h02;
    run_one("stall", 50, 0);

    // Abort mid-scan with reset, then a clean run must show no residue.
    clear_mem();
    for (int i = 0; i < N; i++) mem[i] = 8'hFF;
    start = 1'b1;
    bus.rpt_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.rpt_valid && bus.rpt_row == AW'(4)) break;
      @(posedge clk); #1;
    end
    chk("abort.reached_beat4", bus.rpt_valid && bus.rpt_row == AW'(4), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort.busy", busy, 0);
    chk("abort.rpt_valid", bus.rpt_valid, 0);
    chk("abort.sum_cleared", col_fault_sum, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 2*N + 6; i++) begin
      chk("abort.no_done", done, 0);
      chk("abort.no_beat", bus.rpt_valid, 0);
      @(posedge clk); #1;
    end
    clear_mem(); mem[6] = 8'h40;
    run_one("post_abort", 0, 0);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++)
        mem[i] = N'($urandom & $urandom & $urandom);
      if (r % 2 == 1) begin
        mem[(r+5)%N] = mem[(r+5)%N] | 8'h08;
        mem[(r+6)%N] = mem[(r+6)%N] | 8'h08;
        mem[(r+7)%N] = mem[(r+7)%N] | 8'h08;
      end
      run_one($sformatf("rand%0d", r), 30, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/diag_loop_seq.md
Name: diag_loop_seq

Overview:
- Sequencer for the diagnostic loop-chain block.
- Per run:
  - clears the chain;
  - streams the per-row PE fault bitmaps from the fault memory (eNVM/BIST buffer) into the chain, one row per cycle;
  - rotates the loop once so each row's single-PE map is reported with its row index;
  - accumulates the column-fault and row-fault verdicts into a summary.
- Sits between the BIST controller (start/done) and the diagnostic loop chains.

Parameters:
- SYSTOLIC_SIZE, 8, array dimension N; rows = columns = chain depth; must be >= 3.
- ADDR_WIDTH, $clog2(SYSTOLIC_SIZE), fault-memory row address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  run request; accepted only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse in DONE
- fmem_rd  out  1  fault-memory read strobe
- fmem_addr  out  ADDR_WIDTH  row address being read
- fmem_rdata  in  SYSTOLIC_SIZE  row fault bitmap; valid exactly 1 cycle after fmem_rd
- chain_rst_n  out  1  registered active-low clear to the chain's rst_n
- chain_start_en  out  1  chain shift enable
- chain_col_inputs  out  SYSTOLIC_SIZE  chain column inputs
- single_pe_detection  in  SYSTOLIC_SIZE  chain col_0 (row map at loop head)
- column_fault_detection  in  SYSTOLIC_SIZE  chain column verdicts (registered in chain)
- row_fault_detection  in  SYSTOLIC_SIZE  chain row-detector shift register
- rpt_valid  out  1  report beat valid
- rpt_ready  in  1  report sink ready
- rpt_row  out  ADDR_WIDTH  row index of beat
- rpt_pe_map  out  SYSTOLIC_SIZE  faulty-PE map of that row
- col_fault_sum  out  SYSTOLIC_SIZE  sticky column-fault summary; valid from DONE until next start
- row_fault_flag  out  1  sticky any-row-fault summary; same validity

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=IDLE.
  - All outputs 0, including chain_rst_n=0 so the chain is held cleared.
  - Sums are cleared.
  - Reset mid-run aborts at once: no done pulse, no further report beats.
- IDLE:
  - chain_rst_n=1, chain_start_en=0, chain_col_inputs=0.
  - start=1 -> CLEAR; col_fault_sum and row_fault_flag are cleared on the same edge.
- CLEAR (1 cycle):
  - chain_rst_n=0 (registered, glitch-free).
  - Issues fmem_rd=1, fmem_addr=0.
  - -> LOAD.
- LOAD (N cycles, row counter r=0..N-1):
  - chain_rst_n=1.
  - fmem_rd=1 with fmem_addr=r+1 while r+1<N; 0 on the last cycle.
  - chain_col_inputs=fmem_rdata (the row r data).
  - chain_start_en=1.
  - After the Nth cycle, chain stage k holds row N-1-k. -> SCAN.
- SCAN (N accepted beats, counter s=0..N-1):
  - chain_col_inputs=0.
  - rpt_valid=1, rpt_row=s, rpt_pe_map=single_pe_detection.
  - chain_start_en=rpt_valid&&rpt_ready, so the chain freezes while the sink stalls.
  - s increments on each handshake; the beat with s=N-1 accepted -> SETTLE.
  - Ordering: the head of the loop presents row s at beat s.
- SETTLE (1 cycle):
  - chain_start_en=0.
  - Absorbs the one-cycle register lag of column_fault_detection.
  - -> DONE.
- Accumulation: on every cycle in SCAN where chain_start_en=1, plus in SETTLE:
  - col_fault_sum |= column_fault_detection;
  - row_fault_flag |= |row_fault_detection.
- DONE (1 cycle): done=1, busy=1. -> IDLE.
- start outside IDLE is ignored. start in the DONE cycle is also ignored; a new run needs start in IDLE.
- rpt_pe_map and rpt_row hold stable while rpt_valid=1 and rpt_ready=0.
- Counters saturate at N-1 and are cleared on entry to LOAD/SCAN. There is no wrap-around within a run.
- Latency from start to done with no backpressure: 1 (CLEAR) + N + N + 1 + 1 (DONE) cycles after the start edge, i.e. 2N+3.

Decomposition:
- Shared package holds:
  - state enum (IDLE, CLEAR, LOAD, SCAN, SETTLE, DONE);
  - the fault-memory read-latency constant (1).
- One natural sub-module, diag_fault_accum: the sticky OR of the column/row verdicts with clear and enable.
- The FSM and counters stay in the top.

Test Plan (N=8):
- All-zero memory, rpt_ready=1 -> 8 beats with rpt_row 0..7, all rpt_pe_map=0; col_fault_sum=0, row_fault_flag=0; done exactly 19 cycles after start.
- Row 3 = 8'h10 only -> beat 3 pe_map=8'h10, all others 0; col_fault_sum=0.
- Rows 2,3,4 all = 8'h01 -> beats 2,3,4 = 8'h01; col_fault_sum=8'h01; row_fault_flag=0.
- Row 5 = 8'hE0 -> beat 5 = 8'hE0; row_fault_flag=1; col_fault_sum=0.
- rpt_ready toggled 0/1 with row 1 = 8'h02 -> beats are held stable while stalled; content matches the no-stall run; done is delayed by the number of stall cycles.
- rst_n=0 during SCAN beat 4, then released, then start -> no done from the aborted run; the next run reports fresh data with no residue of the old chain contents.
